// File: rtl/mem_read_streamer_pkg.sv
`default_nettype none
// ============================================================================
// mem_read_streamer_pkg : shared state encoding and default widths
// Rev 1.0 : initial release
// ============================================================================
package mem_read_streamer_pkg;

    localparam int c_DEFAULT_DATA_W = 8;
    localparam int c_DEFAULT_ADDR_W = 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        CAP  = 3'd2,
        SEND = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage : mem_read_streamer_pkg
`default_nettype wire

// File: rtl/mem_read_streamer.sv
`default_nettype none
// ============================================================================
// mem_read_streamer : reads a 1..4 word burst from a fixed-latency memory and
//                     streams it out as valid/ready beats with a last marker
// Rev 1.0 : initial release
// ============================================================================
module mem_read_streamer
    import mem_read_streamer_pkg::*;
#(
    parameter int DATA_W   = c_DEFAULT_DATA_W,
    parameter int ADDR_W   = c_DEFAULT_ADDR_W,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    // Wait counter counts down from READ_LAT-1 so CAP spans exactly READ_LAT cycles.
    localparam logic [1:0] c_WAIT_INIT = 2'(READ_LAT - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_beats;
    logic [1:0]        r_wait;

    assign mem_addr = r_addr;
    assign mem_wr   = 1'b0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_beats   <= '0;
            r_wait    <= '0;
            mem_rd    <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_addr  <= base_addr;
                        r_beats <= count;
                        mem_rd  <= 1'b1;
                        busy    <= 1'b1;
                        r_state <= ADDR;
                    end
                end
                ADDR: begin
                    mem_rd  <= 1'b0;
                    r_wait  <= c_WAIT_INIT;
                    r_state <= CAP;
                end
                CAP: begin
                    if (r_wait == 2'd0) begin
                        out_data  <= mem_rdata;
                        out_valid <= 1'b1;
                        out_last  <= (r_beats == '0);
                        r_state   <= SEND;
                    end else begin
                        r_wait <= r_wait - 2'd1;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (r_beats == '0) begin
                            done    <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            // Address wraps naturally at the memory depth.
                            r_addr  <= r_addr + ADDR_W'(1);
                            r_beats <= r_beats - ADDR_W'(1);
                            mem_rd  <= 1'b1;
                            r_state <= ADDR;
                        end
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : mem_read_streamer
`default_nettype wire

// File: tb/tb_mem_read_streamer.sv
`default_nettype none
// ============================================================================
// tb_mem_read_streamer : scoreboard bench, READ_LAT=1 and READ_LAT=3 instances
// Rev 1.0 : initial release
// ============================================================================
module tb_mem_read_streamer;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic       clk;
    logic       rst_n;

    logic       start_a, ready_a, rd_a, wr_a, valid_a, last_a, busy_a, done_a;
    logic [1:0] base_a, count_a, addr_a;
    logic [7:0] rdata_a, data_a;

    logic       start_b, ready_b, rd_b, wr_b, valid_b, last_b, busy_b, done_b;
    logic [1:0] base_b, count_b, addr_b;
    logic [7:0] rdata_b, data_b;

    logic [7:0] mem [0:3];
    logic [7:0] pa;
    logic [7:0] pb0, pb1, pb2;

    beat_t      q_a[$];
    beat_t      q_b[$];
    logic [1:0] aq_a[$];

    int total = 0;
    int bad   = 0;
    int dd_a  = 0;
    int ndone_a = 0;
    int ndone_b = 0;
    logic wr_seen = 1'b0;

    mem_read_streamer #(.DATA_W(8), .ADDR_W(2), .READ_LAT(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .base_addr(base_a), .count(count_a),
        .mem_addr(addr_a), .mem_rd(rd_a), .mem_wr(wr_a), .mem_rdata(rdata_a),
        .out_data(data_a), .out_valid(valid_a), .out_ready(ready_a), .out_last(last_a),
        .busy(busy_a), .done(done_a)
    );

    mem_read_streamer #(.DATA_W(8), .ADDR_W(2), .READ_LAT(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .base_addr(base_b), .count(count_b),
        .mem_addr(addr_b), .mem_rd(rd_b), .mem_wr(wr_b), .mem_rdata(rdata_b),
        .out_data(data_b), .out_valid(valid_b), .out_ready(ready_b), .out_last(last_b),
        .busy(busy_b), .done(done_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        mem[0] = 8'hA5;
        mem[1] = 8'h3C;
        mem[2] = 8'h7E;
        mem[3] = 8'h01;
    end

    // Memory models: registered read, plus two extra stages for the latency-3 instance.
    always @(posedge clk) begin
        if (rd_a) pa <= mem[addr_a];
        if (rd_b) pb0 <= mem[addr_b];
        pb1 <= pb0;
        pb2 <= pb1;
    end
    assign rdata_a = pa;
    assign rdata_b = pb2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Monitor / scoreboard for both instances.
    always @(negedge clk) begin
        beat_t      b;
        logic [1:0] ea;
        if (wr_a || wr_b) wr_seen = 1'b1;

        if (dd_a == 1) begin
            check("done_pulse", done_a, 1);
            dd_a = 2;
        end else if (dd_a == 2) begin
            check("done_width", done_a, 0);
            dd_a = 0;
        end else if (done_a) begin
            fail_now("spurious_done");
        end
        if (done_a) ndone_a++;
        if (done_b) ndone_b++;

        if (valid_a && ready_a) begin
            if (q_a.size() == 0) fail_now("unexpected_beat_a");
            else begin
                b = q_a.pop_front();
                check("beat_data_a", data_a, b.data);
                check("beat_last_a", last_a, b.last);
            end
            if (last_a) dd_a = 1;
        end
        if (rd_a) begin
            if (aq_a.size() == 0) fail_now("unexpected_read_a");
            else begin
                ea = aq_a.pop_front();
                check("mem_addr_a", addr_a, ea);
            end
        end
        if (valid_b && ready_b) begin
            if (q_b.size() == 0) fail_now("unexpected_beat_b");
            else begin
                b = q_b.pop_front();
                check("beat_data_b", data_b, b.data);
                check("beat_last_b", last_b, b.last);
            end
        end
    end

    task automatic exp_a(input logic [7:0] d, input logic l, input logic [1:0] a);
        beat_t b;
        b.data = d;
        b.last = l;
        q_a.push_back(b);
        aq_a.push_back(a);
    endtask

    task automatic exp_b(input logic [7:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        q_b.push_back(b);
    endtask

    // Called at #1 after an edge; returns at #1 into the cycle after the sampling edge.
    task automatic pulse_a(input logic [1:0] base, input logic [1:0] cnt);
        start_a = 1'b1;
        base_a  = base;
        count_a = cnt;
        @(posedge clk); #1;
        start_a = 1'b0;
    endtask

    task automatic wait_valid_a(output int n);
        n = 0;
        while (!valid_a && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("valid_timeout_a", valid_a, 1);
    endtask

    task automatic wait_done_a();
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done_a && n < 80);
        check("done_timeout_a", done_a, 1);
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_addr"},  addr_a,  0);
        check({tag, "_rd"},    rd_a,    0);
        check({tag, "_wr"},    wr_a,    0);
        check({tag, "_data"},  data_a,  0);
        check({tag, "_valid"}, valid_a, 0);
        check({tag, "_last"},  last_a,  0);
        check({tag, "_busy"},  busy_a,  0);
        check({tag, "_done"},  done_a,  0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        start_a = 1'b0; base_a = '0; count_a = '0; ready_a = 1'b0;
        start_b = 1'b0; base_b = '0; count_b = '0; ready_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_a("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full 4-beat burst, ready held high, latency check.
        ready_a = 1'b1;
        exp_a(8'hA5, 1'b0, 2'd0);
        exp_a(8'h3C, 1'b0, 2'd1);
        exp_a(8'h7E, 1'b0, 2'd2);
        exp_a(8'h01, 1'b1, 2'd3);
        pulse_a(2'd0, 2'd3);
        check("rd_at_k1", rd_a, 1);
        check("busy_at_k1", busy_a, 1);
        wait_valid_a(n);
        check("first_valid_k3", n, 2);
        wait_done_a();
        @(posedge clk); #1;

        // Wrap-around burst 3,0,1.
        exp_a(8'h01, 1'b0, 2'd3);
        exp_a(8'hA5, 1'b0, 2'd0);
        exp_a(8'h3C, 1'b1, 2'd1);
        pulse_a(2'd3, 2'd2);
        wait_done_a();
        @(posedge clk); #1;

        // Single beat with back-pressure: payload must hold.
        ready_a = 1'b0;
        exp_a(8'h3C, 1'b1, 2'd1);
        pulse_a(2'd1, 2'd0);
        wait_valid_a(n);
        for (int i = 0; i < 5; i++) begin
            check("hold_data", data_a, 8'h3C);
            check("hold_last", last_a, 1);
            check("hold_valid", valid_a, 1);
            if (i < 4) begin
                @(posedge clk); #1;
            end
        end
        ready_a = 1'b1;
        @(posedge clk); #1;
        ready_a = 1'b0;
        check("busy_in_done", busy_a, 1);
        @(posedge clk); #1;
        check("busy_after_done", busy_a, 0);
        check("valid_after_done", valid_a, 0);

        // Start pulses mid-burst and in the DONE cycle are ignored.
        ready_a = 1'b1;
        exp_a(8'hA5, 1'b0, 2'd0);
        exp_a(8'h3C, 1'b0, 2'd1);
        exp_a(8'h7E, 1'b0, 2'd2);
        exp_a(8'h01, 1'b1, 2'd3);
        pulse_a(2'd0, 2'd3);
        repeat (4) begin
            @(posedge clk); #1;
        end
        pulse_a(2'd2, 2'd0);
        wait_done_a();
        pulse_a(2'd2, 2'd1);
        check("ignore_done_start_busy", busy_a, 0);
        @(posedge clk); #1;
        check("ignore_done_start_rd", rd_a, 0);
        check("ignore_done_start_busy2", busy_a, 0);

        // Reset while the second beat is waiting in SEND.
        ready_a = 1'b0;
        exp_a(8'hA5, 1'b0, 2'd0);
        aq_a.push_back(2'd1);
        pulse_a(2'd0, 2'd3);
        wait_valid_a(n);
        ready_a = 1'b1;
        @(posedge clk); #1;
        ready_a = 1'b0;
        wait_valid_a(n);
        check("beat2_before_reset", data_a, 8'h3C);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_reset_a("midrst");
        @(posedge clk); #1;
        check("idle_after_midrst", busy_a, 0);

        ready_a = 1'b1;
        exp_a(8'h7E, 1'b0, 2'd2);
        exp_a(8'h01, 1'b1, 2'd3);
        pulse_a(2'd2, 2'd1);
        wait_done_a();
        @(posedge clk); #1;

        // READ_LAT=3 instance: same data, first beat at k+5.
        ready_b = 1'b1;
        exp_b(8'hA5, 1'b0);
        exp_b(8'h3C, 1'b0);
        exp_b(8'h7E, 1'b0);
        exp_b(8'h01, 1'b1);
        start_b = 1'b1;
        base_b  = 2'd0;
        count_b = 2'd3;
        @(posedge clk); #1;
        start_b = 1'b0;
        check("rd_at_k1_b", rd_b, 1);
        n = 0;
        while (!valid_b && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("first_valid_k5_b", n, 4);
        n = 0;
        while (!done_b && n < 80) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_timeout_b", done_b, 1);

        repeat (3) @(posedge clk);
        #1;
        check("beats_left_a", q_a.size(), 0);
        check("reads_left_a", aq_a.size(), 0);
        check("beats_left_b", q_b.size(), 0);
        check("done_count_a", ndone_a, 5);
        check("done_count_b", ndone_b, 1);
        check("mem_wr_seen", wr_seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mem_read_streamer
`default_nettype wire
